// File: rtl/spram_rmw_pkg.sv
// Shared encodings and lane helpers for the byte-addressed RAM adapter.
// Masks are built 32 bits wide and truncated by the user to its cell width.
package spram_rmw_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_CELL = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RDATA = 3'd2,
    MRG   = 3'd3,
    WR    = 3'd4
  } state_t;

  // Bit position of the addressed lane; halfwords are aligned by dropping offset[0].
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return {offset, 3'b000};
      SZ_HALF: return {offset[1], 4'b0000};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 32'h0000_00ff << lane_shift(size, offset);
      SZ_HALF: return 32'h0000_ffff << lane_shift(size, offset);
      default: return 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/spram_rmw_if.sv
// CPU-side data-memory port of the RAM adapter.
interface spram_rmw_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int LSB = $clog2(DATA_WIDTH / 8);

  logic                      req;
  logic                      wr;
  logic [1:0]                size;
  logic [ADDR_WIDTH+LSB-1:0] addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      ack;
  logic                      busy;

  modport master (output req, wr, size, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, wr, size, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/spram_rmw_merge.sv
// Replaces the addressed byte or halfword of a RAM cell with new store data.
module rmw_merge
  import spram_rmw_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int LANES = DATA_WIDTH / 8,
  localparam int LSB = $clog2(LANES)
) (
  input  logic [DATA_WIDTH-1:0] old,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [1:0]            size,
  input  logic [LSB-1:0]        offset,
  output logic [DATA_WIDTH-1:0] merged
);

  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] ins;

  // Store data bits above the access size fall outside the mask and are dropped.
  assign mask   = DATA_WIDTH'(lane_mask(size, 2'(offset)));
  assign ins    = wdata << lane_shift(size, 2'(offset));
  assign merged = (old & ~mask) | (ins & mask);

endmodule

// File: rtl/spram_rmw.sv
// Byte-addressed adapter onto a single-port RAM without lane enables; sub-cell
// stores are read-modify-write, sub-cell fetches return the lane zero-extended.
module spram_rmw
  import spram_rmw_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  localparam int LANES = DATA_WIDTH / 8,
  localparam int LSB = $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  arstn,
  spram_rmw_if.slave            bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [LANES-1:0]      ram_lane
);

  // state | meaning
  // IDLE  | waiting for req
  // RD    | ram_re issued, cell read in flight
  // RDATA | ram_dout valid, fetch acknowledged
  // MRG   | ram_dout valid, merged cell loaded into ram_din
  // WR    | ram_we issued, store acknowledged
  state_t                state;
  logic                  wr_q;
  logic [1:0]            size_q;
  logic [LSB-1:0]        off_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  ack_q;
  logic [1:0]            req_size;
  logic [DATA_WIDTH-1:0] merged;

  // A halfword fills a whole 16-bit cell, so it is treated as a full-cell access.
  always_comb begin
    req_size = bus.size;
    if (bus.size[1] || (bus.size == SZ_HALF && LANES == 2)) req_size = SZ_CELL;
  end

  rmw_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old    (ram_dout),
    .wdata  (wdata_q),
    .size   (size_q),
    .offset (off_q),
    .merged (merged)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      wr_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      off_q    <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      ack_q  <= 1'b0;
      ram_we <= 1'b0;
      ram_re <= 1'b0;
      case (state)
        IDLE: if (bus.req) begin
          ram_addr <= bus.addr[ADDR_WIDTH+LSB-1:LSB];
          off_q    <= bus.addr[LSB-1:0];
          size_q   <= req_size;
          wr_q     <= bus.wr;
          wdata_q  <= bus.wdata;
          if (bus.wr && req_size == SZ_CELL) begin
            ram_din <= bus.wdata;
            ram_we  <= 1'b1;
            ack_q   <= 1'b1;
            state   <= WR;
          end else begin
            ram_re <= 1'b1;
            state  <= RD;
          end
        end
        RD: begin
          if (wr_q) begin
            state <= MRG;
          end else begin
            ack_q <= 1'b1;
            state <= RDATA;
          end
        end
        RDATA: state <= IDLE;
        MRG: begin
          ram_din <= merged;
          ram_we  <= 1'b1;
          ack_q   <= 1'b1;
          state   <= WR;
        end
        WR:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack   = ack_q;
  assign bus.busy  = (state != IDLE);
  assign bus.rdata = (ram_dout & DATA_WIDTH'(lane_mask(size_q, 2'(off_q))))
                     >> lane_shift(size_q, 2'(off_q));
  assign ram_lane  = '1;

endmodule

// File: tb/tb_spram_rmw.sv
// Directed bench for spram_rmw: 32-bit and 16-bit builds, each on a behavioural RAM.
module tb_spram_rmw;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  spram_rmw_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) b32 ();
  spram_rmw_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) b16 ();

  logic [9:0]  r32_addr, r16_addr;
  logic [31:0] r32_din, r32_dout;
  logic [15:0] r16_din, r16_dout;
  logic        r32_we, r32_re, r16_we, r16_re;
  logic [3:0]  r32_lane;
  logic [1:0]  r16_lane;

  spram_rmw #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut32 (
    .clk(clk), .arstn(arstn), .bus(b32),
    .ram_addr(r32_addr), .ram_din(r32_din), .ram_dout(r32_dout),
    .ram_we(r32_we), .ram_re(r32_re), .ram_lane(r32_lane)
  );

  spram_rmw #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut16 (
    .clk(clk), .arstn(arstn), .bus(b16),
    .ram_addr(r16_addr), .ram_din(r16_din), .ram_dout(r16_dout),
    .ram_we(r16_we), .ram_re(r16_re), .ram_lane(r16_lane)
  );

  logic [31:0] mem32 [0:1023];
  logic [15:0] mem16 [0:1023];

  always @(posedge clk) begin
    if (r32_we) mem32[r32_addr] <= r32_din;
    if (r32_re) r32_dout <= mem32[r32_addr];
    if (r16_we) mem16[r16_addr] <= r16_din;
    if (r16_re) r16_dout <= mem16[r16_addr];
  end

  int cnt_we = 0, cnt_re = 0, cnt_ack = 0, cnt_both = 0;
  always @(negedge clk) begin
    if (r32_we || r16_we) cnt_we++;
    if (r32_re || r16_re) cnt_re++;
    if (b32.ack || b16.ack) cnt_ack++;
    if ((r32_we && r32_re) || (r16_we && r16_re)) cnt_both++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w16, input logic req, input logic wr, input logic [1:0] size,
                       input logic [11:0] addr, input logic [31:0] wdata);
    if (w16) begin
      b16.req = req; b16.wr = wr; b16.size = size; b16.addr = addr[10:0]; b16.wdata = wdata[15:0];
    end else begin
      b32.req = req; b32.wr = wr; b32.size = size; b32.addr = addr; b32.wdata = wdata;
    end
  endtask

  task automatic op(input bit w16, input logic wr, input logic [1:0] size, input logic [11:0] addr,
                    input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                    output logic [31:0] din, output logic [31:0] ra, output int nwe, output int nre);
    int we0, re0;
    lat = 99; rd = '0; din = '0; ra = '0;
    @(negedge clk);
    drive(w16, 1'b1, wr, size, addr, wdata);
    @(posedge clk); #1;
    drive(w16, 1'b0, 1'b0, 2'd0, 12'h0, 32'h0);
    we0 = cnt_we; re0 = cnt_re;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if ((w16 ? b16.ack : b32.ack) === 1'b1) begin
        lat = c;
        rd  = w16 ? {16'h0, b16.rdata} : b32.rdata;
        din = w16 ? {16'h0, r16_din} : r32_din;
        ra  = w16 ? {22'h0, r16_addr} : {22'h0, r32_addr};
        break;
      end
    end
    @(posedge clk); #1;
    nwe = cnt_we - we0;
    nre = cnt_re - re0;
  endtask

  typedef struct {
    bit          w16;
    logic        wr;
    logic [1:0]  size;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
    logic [31:0] exp_ra;
    int          exp_nwe;
    int          exp_nre;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int lat, nwe, nre, nack, a1, a2, we0, ack0;
    logic [31:0] rd, din, ra, din1, rd2;

    vecs[0]  = '{0, 1, 2'd2, 12'h010, 32'h12345678, 32'h12345678, 1, 32'd4, 1, 0};
    vecs[1]  = '{0, 0, 2'd0, 12'h010, 32'h0, 32'h00000078, 2, 32'd4, 0, 1};
    vecs[2]  = '{0, 0, 2'd0, 12'h011, 32'h0, 32'h00000056, 2, 32'd4, 0, 1};
    vecs[3]  = '{0, 0, 2'd0, 12'h012, 32'h0, 32'h00000034, 2, 32'd4, 0, 1};
    vecs[4]  = '{0, 0, 2'd0, 12'h013, 32'h0, 32'h00000012, 2, 32'd4, 0, 1};
    vecs[5]  = '{0, 0, 2'd1, 12'h013, 32'h0, 32'h00001234, 2, 32'd4, 0, 1};
    vecs[6]  = '{0, 0, 2'd1, 12'h010, 32'h0, 32'h00005678, 2, 32'd4, 0, 1};
    vecs[7]  = '{0, 1, 2'd0, 12'h011, 32'hFFFFFFAB, 32'h1234AB78, 3, 32'd4, 1, 1};
    vecs[8]  = '{0, 0, 2'd2, 12'h010, 32'h0, 32'h1234AB78, 2, 32'd4, 0, 1};
    vecs[9]  = '{0, 0, 2'd3, 12'h012, 32'h0, 32'h1234AB78, 2, 32'd4, 0, 1};
    vecs[10] = '{0, 1, 2'd3, 12'hFFE, 32'hA5A55A5A, 32'hA5A55A5A, 1, 32'h3FF, 1, 0};
    vecs[11] = '{1, 1, 2'd2, 12'h000, 32'h1234, 32'h00001234, 1, 32'd0, 1, 0};
    vecs[12] = '{1, 1, 2'd0, 12'h001, 32'hEECD, 32'h0000CD34, 3, 32'd0, 1, 1};
    vecs[13] = '{1, 0, 2'd1, 12'h001, 32'h0, 32'h0000CD34, 2, 32'd0, 0, 1};
    vecs[14] = '{1, 1, 2'd1, 12'h003, 32'h5678, 32'h00005678, 1, 32'd1, 1, 0};
    vecs[15] = '{1, 0, 2'd0, 12'h003, 32'h0, 32'h00000056, 2, 32'd1, 0, 1};
    vecs[16] = '{1, 0, 2'd0, 12'h002, 32'h0, 32'h00000078, 2, 32'd1, 0, 1};

    for (int i = 0; i < 1024; i++) begin mem32[i] = '0; mem16[i] = '0; end
    drive(0, 1'b0, 1'b0, 2'd0, 12'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 12'h0, 32'h0);

    #12;
    check("rst_busy", {31'h0, b32.busy}, 32'h0);
    check("rst_ack", {31'h0, b32.ack}, 32'h0);
    check("rst_we_re", {30'h0, r32_we, r32_re}, 32'h0);
    check("rst_ram_addr", {22'h0, r32_addr}, 32'h0);
    check("rst_ram_din", r32_din, 32'h0);
    check("lane32", {28'h0, r32_lane}, 32'hF);
    check("lane16", {30'h0, r16_lane}, 32'h3);
    @(negedge clk); arstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      op(vecs[i].w16, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, lat, rd, din, ra, nwe, nre);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      if (vecs[i].wr) check($sformatf("v%0d_din", i), din, vecs[i].exp_data);
      else            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_data);
      check($sformatf("v%0d_ram_addr", i), ra, vecs[i].exp_ra);
      check($sformatf("v%0d_we_count", i), nwe, vecs[i].exp_nwe);
      check($sformatf("v%0d_re_count", i), nre, vecs[i].exp_nre);
    end

    // Halfword store with req held high into a following cell fetch.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 2'd1, 12'h012, 32'h1111BEEF);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 2'd2, 12'h010, 32'h0);
    nack = 0; a1 = 0; a2 = 0; din1 = '0; rd2 = '0;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 2) check("held_busy_mrg", {31'h0, b32.busy}, 32'h1);
      if (c == 4) check("held_busy_idle", {31'h0, b32.busy}, 32'h0);
      if (b32.ack === 1'b1) begin
        nack++;
        if (nack == 1) begin a1 = c; din1 = r32_din; end
        else if (nack == 2) begin a2 = c; rd2 = b32.rdata; b32.req = 1'b0; end
      end
    end
    b32.req = 1'b0;
    check("held_ack_count", nack, 2);
    check("held_ack1_cycle", a1, 3);
    check("held_ack2_cycle", a2, 6);
    check("held_half_din", din1, 32'hBEEFAB78);
    check("held_fetch_rdata", rd2, 32'hBEEFAB78);

    // Reset pulse while a byte store sits in MRG.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 2'd0, 12'h010, 32'h55);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'd0, 12'h0, 32'h0);
    we0 = cnt_we; ack0 = cnt_ack;
    @(posedge clk); #1;
    check("mrg_busy_before_rst", {31'h0, b32.busy}, 32'h1);
    arstn = 1'b0;
    #2;
    check("mrg_rst_busy", {31'h0, b32.busy}, 32'h0);
    check("mrg_rst_outputs", {29'h0, r32_we, r32_re, b32.ack}, 32'h0);
    check("mrg_rst_ram_din", r32_din, 32'h0);
    @(negedge clk); arstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mrg_rst_no_write", cnt_we - we0, 0);
    check("mrg_rst_no_ack", cnt_ack - ack0, 0);
    check("mrg_rst_busy_after", {31'h0, b32.busy}, 32'h0);
    op(0, 1'b0, 2'd2, 12'h010, 32'h0, lat, rd, din, ra, nwe, nre);
    check("mrg_rst_cell_kept", rd, 32'hBEEFAB78);

    check("we_re_overlap", cnt_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spram_rmw.md
Name: spram_rmw

Overview:
- Byte-addressed access adapter between the CPU data-memory port and a single-port synchronous RAM that has no usable byte-lane enables.
- Sub-cell stores (c!, w!) are done by read-modify-write: read the cell, merge the new byte or halfword, write the cell back.
- Sub-cell reads return the selected lane, zero-extended.
- Sits directly upstream of the data RAM and drives its addr/din/we/re/lane pins.

Parameters:
- ADDR_WIDTH, 10, cell-address width of the RAM.
- DATA_WIDTH, 32, cell width; legal values are 16 and 32.
- LANES, DATA_WIDTH/8, derived localparam (bytes per cell).
- LSB, log2(LANES), derived localparam (byte-offset bits).

Ports:
- clk  in  1  clock, rising edge.
- arstn  in  1  asynchronous active-low reset.
- req  in  1  request strobe; sampled only when busy=0.
- wr  in  1  1 = store, 0 = fetch.
- size  in  2  0 = byte, 1 = halfword, 2 or 3 = full cell.
- addr  in  ADDR_WIDTH+LSB  byte address.
- wdata  in  DATA_WIDTH  store data, right-justified.
- rdata  out  DATA_WIDTH  fetch data, zero-extended; valid only while ack=1.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state is not IDLE.
- ram_addr  out  ADDR_WIDTH  cell address to RAM.
- ram_din  out  DATA_WIDTH  write data to RAM.
- ram_dout  in  DATA_WIDTH  RAM read data; valid the cycle after ram_re.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_lane  out  LANES  tied all-ones.

Behaviour:
- Reset (async, arstn=0): state=IDLE; ack=0, ram_we=0, ram_re=0, busy=0, ram_addr=0, ram_din=0; lane/size registers cleared. Reset mid-operation abandons the access: no write is issued and no ack is given.
- All RAM-side outputs and ack are registered. rdata is combinational from ram_dout plus the registered offset and size.
- Memory is little-endian: byte k of a cell is bits [8k+7:8k], and k = addr[LSB-1:0].
- A halfword ignores addr[0]. With DATA_WIDTH=16, size 1 behaves as a full cell.
- FSM states and transitions:
  - IDLE: if req=1, latch addr/size/wr/wdata.
    - Full-cell store: go to WR with ram_we=1, ram_din=wdata.
    - Any other access: go to RD with ram_re=1.
  - RD: ram_re=1 for one cycle. Next state is RDATA for a fetch, MRG for a store.
  - RDATA: ack=1. rdata = (ram_dout >> 8*offset) masked to 8, 16 or DATA_WIDTH bits. Next state IDLE.
  - MRG: ram_din is loaded with ram_dout, with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. Next state WR.
  - WR: ram_we=1, ack=1. Next state IDLE.
- Latency, counted from the edge that samples req to ack high:
  - Full-cell store: 1 cycle.
  - Fetch: 2 cycles.
  - Sub-cell store: 3 cycles.
- ram_we and ram_re are never both high.
- req while busy=1 is ignored and not queued; the master holds req until it sees ack.
- The earliest new request is sampled in the cycle after ack, once the state is back to IDLE.
- wdata bits above the access size are ignored.
- addr is the byte address. ram_addr is addr[ADDR_WIDTH+LSB-1:LSB]; the top byte address wraps naturally.

Decomposition:
- Shared package holds:
  - Size encoding constants SZ_BYTE=0, SZ_HALF=1, SZ_CELL=2.
  - FSM state encoding: IDLE, RD, RDATA, MRG, WR.
  - Function lane_mask(size, offset) returning a DATA_WIDTH-bit mask.
- One combinational sub-module, rmw_merge, takes (old, wdata, size, offset) and returns the merged cell. It is reused for fetch alignment by the shift/mask logic.

Test Plan:
- Reset, then a full-cell store (DATA_WIDTH=32) of 0x12345678 to byte address 0x10 -> ram_we pulse with ram_addr=4, ram_din=0x12345678; ack 1 cycle after the request; ram_re never high.
- Cell 4 holds 0x12345678; byte fetch at addresses 0x10 through 0x13 -> rdata = 0x78, 0x56, 0x34, 0x12 respectively; ack 2 cycles after each request; halfword fetch at 0x13 -> 0x1234.
- Byte store 0xAB to 0x11 -> ram_re, then ram_we with ram_din=0x1234AB78; ack 3 cycles after the request; a following cell fetch returns 0x1234AB78.
- Halfword store 0xBEEF to 0x12, followed by req held high through busy -> cell becomes 0xBEEFAB78; the held second request is sampled only in the cycle after ack; exactly one ack per request.
- arstn pulsed low during MRG of a byte store -> ram_we never asserted, ack never asserted, cell contents unchanged, busy=0 after reset.
- DATA_WIDTH=16 build: byte store 0xCD to byte address 1 of a cell holding 0x1234 -> 0xCD34; size=1 behaves as a full-cell store (1-cycle ack, no ram_re).
